// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, memory depth, word size.
// The memory depth is shared with the instruction memory so both sides agree on the array size.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCollect = 2'd1,
      StWrite   = 2'd2,
      StDone    = 2'd3
   } state_e;

   localparam int unsigned IMEM_DEPTH_BYTES = 100;
   localparam int unsigned WORD_BYTES       = 4;

endpackage

// File: rtl/be_word_packer.sv
// Big-endian byte-to-word packer: the first byte of each group lands in [31:24].
// word_full flags the cycle in which the fourth byte of a group is accepted.
module be_word_packer (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        byte_strobe,
   input  logic [7:0]  byte_in,
   input  logic        clear,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0]  lane_q;
   logic [31:0] word_q;

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         lane_q <= 2'd0;
         word_q <= 32'h0;
      end else begin
         if (clear) begin
            lane_q <= 2'd0;
         end else if (byte_strobe) begin
            lane_q <= lane_q + 2'd1;
         end
         // Shifting in from the bottom leaves the first byte in the top lane after four strobes.
         if (byte_strobe && !clear) begin
            word_q <= {word_q[23:0], byte_in};
         end
      end
   end

   assign word      = word_q;
   assign word_full = byte_strobe && (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes from a host link into word writes on the instruction memory write port.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a mod-256 checksum of accepted bytes.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = IMEM_DEPTH_BYTES,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] word_count,
   output logic [7:0]       checksum
);

   localparam int unsigned WordShift = $clog2(WORD_BYTES);
   localparam logic [31:0] Capacity  = 32'(DEPTH_BYTES - BASE_ADDR);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] word_count_q;
   logic             error_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;

   logic             start_ok;
   logic             accept;
   logic             too_big;
   logic             last_word;
   logic             packer_clear;
   logic             word_full;
   logic [31:0]      packed_word;
   logic [31:0]      write_addr;
   logic [CNT_W+1:0] need_bytes;

   // Two extra bits so num_words * 4 can never wrap before the comparison.
   assign need_bytes   = {2'b00, num_words} << WordShift;
   assign too_big      = 32'(need_bytes) > Capacity;
   assign start_ok     = start && (state_q == StIdle || state_q == StDone);
   assign accept       = byte_valid && byte_ready;
   assign last_word    = (word_count_q + CNT_W'(1)) == num_q;
   assign write_addr   = 32'(BASE_ADDR) + (32'(word_count_q) << WordShift);
   assign packer_clear = start_ok || (state_q == StWrite);

   be_word_packer u_packer (
      .CLK         (CLK),
      .Reset       (Reset),
      .byte_strobe (accept),
      .byte_in     (byte_data),
      .clear       (packer_clear),
      .word        (packed_word),
      .word_full   (word_full)
   );

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_ok) begin
               if (too_big || num_words == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StCollect;
               end
            end
         end
         StCollect: begin
            if (word_full) state_d = StWrite;
         end
         StWrite: begin
            state_d = last_word ? StDone : StCollect;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      unique case (state_q)
         StCollect: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
         end
         StWrite: begin
            mem_we    = 1'b1;
            busy      = 1'b1;
            mem_addr  = write_addr;
            mem_wdata = packed_word;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // Address and data registers keep the last written word visible outside the write cycle.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         num_q        <= '0;
         word_count_q <= '0;
         error_q      <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
      end else if (start_ok) begin
         num_q        <= num_words;
         word_count_q <= '0;
         error_q      <= too_big;
      end else if (state_q == StWrite) begin
         word_count_q <= word_count_q + CNT_W'(1);
         addr_q       <= write_addr;
         wdata_q      <= packed_word;
      end
   end

   assign word_count = word_count_q;
   assign error      = error_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] checksum_q;

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         checksum_q <= 8'h00;
      end else if (start_ok) begin
         checksum_q <= 8'h00;
      end else if (accept) begin
         checksum_q <= checksum_q + byte_data;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory. It receives a program as a byte stream, for example from a UART or testbench.
- It packs each group of four bytes into a big-endian 32-bit word: first byte goes to [31:24], last byte to [7:0].
- It issues one word-write per packed word into the byte-addressed instruction memory array.
- It sits between the host link and the memory's write port and runs before CPU fetch is released.

Parameters:
- DEPTH_BYTES, 100, size of the target memory in bytes; the legal byte address range is 0..DEPTH_BYTES-1.
- BASE_ADDR, 0, byte address of the first word written.
- CNT_W, 8, width of num_words and word_count.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load. Ignored unless the state is IDLE or DONE.
- num_words  in  CNT_W  number of 32-bit words to load; sampled when start is accepted.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle. A byte transfers only when byte_valid=1 and byte_ready=1.
- mem_we  out  1  one-cycle word-write strobe.
- mem_addr  out  32  byte address of the word written; always a multiple of 4.
- mem_wdata  out  32  big-endian packed word.
- busy  out  1  load in progress.
- done  out  1  load finished; held until the next accepted start.
- error  out  1  the requested load does not fit in memory; held until the next accepted start.
- word_count  out  CNT_W  number of words written in the current load.
- checksum  out  8  see Optional Feature.

Behaviour:
- Reset values (Reset=0 at a clock edge): state=IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, word_count=0, checksum=0. The byte lane counter and the latched length are also cleared.
- State machine states: IDLE, COLLECT, WRITE, DONE.
- IDLE or DONE, on start:
  - Latch num_words, clear done, error and word_count.
  - If num_words*4 > DEPTH_BYTES-BASE_ADDR: go to DONE with error=1 and perform no writes.
  - Else if num_words=0: go to DONE.
  - Else: go to COLLECT, with busy=1.
  - Compute the size check at CNT_W+2 bits so it cannot overflow.
- COLLECT:
  - byte_ready=1.
  - Each accepted byte is placed into lane 0..3, in order [31:24], [23:16], [15:8], [7:0].
  - When the 4th byte is accepted, go to WRITE.
  - byte_valid=0 stalls the loader indefinitely with no timeout.
- WRITE, exactly one cycle:
  - byte_ready=0, mem_we=1.
  - mem_addr=BASE_ADDR+4*word_count; mem_wdata=packed word.
  - The write is visible on the port in the cycle after the 4th byte handshake.
  - word_count increments at the end of this cycle.
  - If word_count+1 = num_words, go to DONE; else go to COLLECT with the lane reset to 0.
- DONE: busy=0, done=1, byte_ready=0. mem_we=0 in every state other than WRITE.
- Outside WRITE: mem_addr and mem_wdata hold their last values.
- start while busy: ignored, with no effect on the latched length.
- Bytes presented while byte_ready=0: not consumed; the source must hold them.
- Reset mid-load: immediate return to IDLE. The partial word is discarded and no write is issued for it. Words already written remain in memory, and memory is not cleared.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: checksum is the mod-256 sum of every byte accepted since the last accepted start. It is cleared on start and on reset, and is stable while done=1.
- Undefined: no accumulator is built and checksum is tied to 0.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE/COLLECT/WRITE/DONE;
  - the default memory depth of 100, shared with the instruction memory so both agree;
  - the word size of 4 bytes.
- One natural sub-module: be_word_packer.
  - Contains the lane counter and a 32-bit shift/assemble register.
  - Inputs: byte strobe, byte, clear.
  - Outputs: word, word_full.
  - The FSM and the address/count logic stay in imem_loader.

Test Plan:
- Basic load: num_words=2, back-to-back bytes 00 01 02 03 04 05 06 07. Required: mem_we at addr 0 with data 0x00010203, then at addr 4 with 0x04050607. After that, done=1, word_count=2, busy=0.
- Back-pressure: same load with byte_valid toggling every other cycle, plus one 10-cycle gap mid-word. Required: identical writes and data, and mem_we only one cycle after each 4th byte.
- Size check, DEPTH_BYTES=100:
  - num_words=26 → error=1, done=1, no mem_we ever.
  - num_words=25 → 25 writes, last at addr 96, error=0.
  - num_words=0 → done=1 the cycle after start, no writes.
- Reset mid-word: after 6 of 8 bytes (1 write done), pull Reset low for 1 cycle. Required: all outputs at reset values and no second write. A new start with 4 bytes writes addr 0.
- start during busy: pulse start with num_words=5 mid-load of 2 words. Required: ignored, and exactly 2 writes.
- With IMEM_LOADER_CHECKSUM_EN: bytes FF 01 10 20 → checksum=0x30 at done. Without the macro, checksum=0 throughout.
